// File: rtl/pipeline_flush_ctrl.sv
// Pipeline flush/stall/bubble controller with a registered fetch redirect.
// Resolves branch mispredicts, exceptions, ertn and idle into per-stage squash/hold controls.
module pipeline_flush_ctrl #(
  parameter int ADDR_WIDTH = 32,
  parameter int STAGES     = 5,
  parameter int MISS_STAGE = 2,
  parameter int EXC_STAGE  = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  predict_miss,
  input  logic [ADDR_WIDTH-1:0] real_addr,
  input  logic                  exp_en,
  input  logic [ADDR_WIDTH-1:0] trap_entry,
  input  logic                  e_ret,
  input  logic [ADDR_WIDTH-1:0] epc,
  input  logic                  idle_req,
  input  logic [STAGES-1:0]     stall_req,
  input  logic                  redirect_ready,
  output logic [STAGES-1:0]     flush,
  output logic [STAGES-1:0]     stall,
  output logic [STAGES-1:0]     bubble,
  output logic                  redirect_valid,
  output logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  idle_state,
  output logic [31:0]           flush_cnt
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_REDIRECT = 2'd1,
    ST_IDLE     = 2'd2
  } state_t;

  // Mask with bits [n-1:0] set; used for the per-event squash ranges.
  function automatic logic [STAGES-1:0] low_mask(input int n);
    logic [STAGES-1:0] m;
    m = '0;
    for (int i = 0; i < STAGES; i++) begin
      if (i < n) m[i] = 1'b1;
    end
    return m;
  endfunction

  localparam logic [STAGES-1:0] EXC_MASK  = low_mask(EXC_STAGE + 1);
  localparam logic [STAGES-1:0] IDLE_MASK = low_mask(EXC_STAGE);
  localparam logic [STAGES-1:0] MISS_MASK = low_mask(MISS_STAGE);

  state_t                  state;
  state_t                  state_next;
  logic [ADDR_WIDTH-1:0]   pc_q;
  logic [31:0]             cnt_q;

  logic                    take_exc;
  logic                    take_ret;
  logic                    take_miss;
  logic                    take_idle;
  logic                    load;
  logic [ADDR_WIDTH-1:0]   load_pc;
  logic [STAGES-1:0]       stall_raw;
  logic [STAGES-1:0]       bubble_raw;

  // Event qualification: which inputs count as events depends on the current state.
  always_comb begin
    // NOTE: every signal written here gets a default first so no latch is inferred.
    take_exc  = 1'b0;
    take_ret  = 1'b0;
    take_miss = 1'b0;
    take_idle = 1'b0;
    case (state)
      ST_RUN: begin
        take_exc  = exp_en;
        take_ret  = e_ret & ~exp_en;
        take_idle = idle_req & ~exp_en & ~e_ret;
        take_miss = predict_miss & ~exp_en & ~e_ret & ~idle_req;
      end
      ST_REDIRECT: begin
        take_exc = exp_en;
        take_ret = e_ret & ~exp_en;
      end
      ST_IDLE: begin
        take_exc = exp_en;
      end
      default: ;
    endcase
  end

  assign load    = take_exc | take_ret | take_miss;
  assign load_pc = take_exc ? trap_entry :
                   take_ret ? epc        : real_addr;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_RUN;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      ST_RUN: begin
        if (load)           state_next = ST_REDIRECT;
        else if (take_idle) state_next = ST_IDLE;
      end
      ST_REDIRECT: begin
        if (load)                state_next = ST_REDIRECT;
        else if (redirect_ready) state_next = ST_RUN;
      end
      ST_IDLE: begin
        if (load) state_next = ST_REDIRECT;
      end
      default: state_next = ST_RUN;
    endcase
  end

  // Output logic: squash ranges plus the standing fetch squash while redirecting or idle.
  always_comb begin
    flush = '0;
    case (state)
      ST_REDIRECT, ST_IDLE: flush[0] = 1'b1;
      default: ;
    endcase
    if (take_exc || take_ret) flush = flush | EXC_MASK;
    else if (take_idle)       flush = flush | IDLE_MASK;
    else if (take_miss)       flush = flush | MISS_MASK;

    redirect_valid = (state == ST_REDIRECT);
    idle_state     = (state == ST_IDLE);
  end

  // A stall anywhere downstream holds every upstream stage; a bubble enters at the boundary.
  always_comb begin
    stall_raw  = '0;
    bubble_raw = '0;
    for (int i = 0; i < STAGES; i++) begin
      stall_raw[i] = |(stall_req >> i);
    end
    for (int i = 0; i < STAGES - 1; i++) begin
      bubble_raw[i+1] = stall_raw[i] & ~stall_raw[i+1];
    end
    stall  = stall_raw & ~flush;
    bubble = bubble_raw & ~flush;
  end

  // Redirect target and saturating event counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q  <= '0;
      cnt_q <= '0;
    end else if (load) begin
      pc_q <= load_pc;
      if (cnt_q != 32'hFFFF_FFFF) cnt_q <= cnt_q + 32'd1;
    end
  end

  assign redirect_pc = pc_q;
  assign flush_cnt   = cnt_q;

endmodule

// File: tb/tb_pipeline_flush_ctrl.sv
// Self-checking bench for pipeline_flush_ctrl: vector table, directed corner sequences
// and randomized traffic compared against an event-level reference model.
module tb_pipeline_flush_ctrl;

  localparam int AW = 32;
  localparam int ST = 5;
  localparam int MS = 2;
  localparam int ES = 3;

  localparam logic [ST-1:0] EXC_F  = ST'((1 << (ES + 1)) - 1);
  localparam logic [ST-1:0] IDLE_F = ST'((1 << ES) - 1);
  localparam logic [ST-1:0] MISS_F = ST'((1 << MS) - 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          predict_miss;
  logic [AW-1:0] real_addr;
  logic          exp_en;
  logic [AW-1:0] trap_entry;
  logic          e_ret;
  logic [AW-1:0] epc;
  logic          idle_req;
  logic [ST-1:0] stall_req;
  logic          redirect_ready;
  logic [ST-1:0] flush;
  logic [ST-1:0] stall;
  logic [ST-1:0] bubble;
  logic          redirect_valid;
  logic [AW-1:0] redirect_pc;
  logic          idle_state;
  logic [31:0]   flush_cnt;

  pipeline_flush_ctrl #(
    .ADDR_WIDTH(AW), .STAGES(ST), .MISS_STAGE(MS), .EXC_STAGE(ES)
  ) dut (
    .clk(clk), .rst(rst),
    .predict_miss(predict_miss), .real_addr(real_addr),
    .exp_en(exp_en), .trap_entry(trap_entry),
    .e_ret(e_ret), .epc(epc),
    .idle_req(idle_req), .stall_req(stall_req),
    .redirect_ready(redirect_ready),
    .flush(flush), .stall(stall), .bubble(bubble),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .idle_state(idle_state), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: redirect pending / idle flags, held target and event count.
  bit          m_pending;
  bit          m_idle;
  logic [AW-1:0] m_pc;
  logic [31:0] m_cnt;

  task automatic model_reset();
    m_pending = 0;
    m_idle    = 0;
    m_pc      = '0;
    m_cnt     = '0;
  endtask

  task automatic model_comb(output logic [ST-1:0] f, output logic [ST-1:0] s,
                            output logic [ST-1:0] b, output bit ld,
                            output logic [AW-1:0] npc, output bit go_idle);
    logic [ST-1:0] raw;
    f = '0; ld = 0; npc = m_pc; go_idle = 0;
    if (m_idle) begin
      f[0] = 1'b1;
      if (exp_en) begin f = f | EXC_F; ld = 1; npc = trap_entry; end
    end else if (m_pending) begin
      f[0] = 1'b1;
      if (exp_en || e_ret) begin f = f | EXC_F; ld = 1; npc = exp_en ? trap_entry : epc; end
    end else if (exp_en || e_ret) begin
      f = EXC_F; ld = 1; npc = exp_en ? trap_entry : epc;
    end else if (idle_req) begin
      f = IDLE_F; go_idle = 1;
    end else if (predict_miss) begin
      f = MISS_F; ld = 1; npc = real_addr;
    end
    raw = '0;
    for (int i = 0; i < ST; i++) raw[i] = ((stall_req >> i) != 0);
    b = '0;
    for (int i = 0; i < ST - 1; i++) b[i+1] = raw[i] & ~raw[i+1];
    s = raw & ~f;
    b = b & ~f;
  endtask

  task automatic model_clock(input bit ld, input logic [AW-1:0] npc, input bit go_idle);
    if (ld) begin
      m_pending = 1; m_idle = 0; m_pc = npc;
      if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
    end else if (m_pending && redirect_ready) begin
      m_pending = 0;
    end else if (go_idle) begin
      m_idle = 1;
    end
  endtask

  task automatic clear_inputs();
    predict_miss = 0; exp_en = 0; e_ret = 0; idle_req = 0;
    redirect_ready = 0; stall_req = '0;
    real_addr = '0; trap_entry = '0; epc = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    clear_inputs();
    tick();
    tick();
    rst = 1'b0;
    model_reset();
  endtask

  typedef struct {
    logic [ST-1:0] sreq;
    logic          pm, ex, er, id;
    logic [ST-1:0] f, s, b;
  } vec_t;

  vec_t vecs[15];

  logic [ST-1:0] ef, es, eb;
  bit            eld, eidle;
  logic [AW-1:0] enpc;

  initial begin
    vecs[0]  = '{5'b00000, 0, 0, 0, 0, 5'b00000, 5'b00000, 5'b00000};
    vecs[1]  = '{5'b00100, 0, 0, 0, 0, 5'b00000, 5'b00111, 5'b01000};
    vecs[2]  = '{5'b00100, 0, 1, 0, 0, 5'b01111, 5'b00000, 5'b00000};
    vecs[3]  = '{5'b00000, 1, 0, 0, 0, 5'b00011, 5'b00000, 5'b00000};
    vecs[4]  = '{5'b00000, 1, 1, 0, 0, 5'b01111, 5'b00000, 5'b00000};
    vecs[5]  = '{5'b00000, 1, 0, 1, 0, 5'b01111, 5'b00000, 5'b00000};
    vecs[6]  = '{5'b00000, 0, 0, 0, 1, 5'b00111, 5'b00000, 5'b00000};
    vecs[7]  = '{5'b00000, 1, 0, 0, 1, 5'b00111, 5'b00000, 5'b00000};
    vecs[8]  = '{5'b10000, 0, 0, 0, 0, 5'b00000, 5'b11111, 5'b00000};
    vecs[9]  = '{5'b10000, 1, 0, 0, 0, 5'b00011, 5'b11100, 5'b00000};
    vecs[10] = '{5'b00001, 0, 0, 0, 0, 5'b00000, 5'b00001, 5'b00010};
    vecs[11] = '{5'b01010, 0, 0, 0, 0, 5'b00000, 5'b01111, 5'b10000};
    vecs[12] = '{5'b00010, 1, 0, 0, 0, 5'b00011, 5'b00000, 5'b00100};
    vecs[13] = '{5'b00100, 0, 0, 0, 1, 5'b00111, 5'b00000, 5'b01000};
    vecs[14] = '{5'b10000, 0, 1, 0, 0, 5'b01111, 5'b10000, 5'b00000};

    // Reset values, observed while reset is held
    rst = 1'b1;
    clear_inputs();
    #1;
    tick();
    check("rst redirect_valid", redirect_valid, 0);
    check("rst redirect_pc", redirect_pc, 0);
    check("rst idle_state", idle_state, 0);
    check("rst flush_cnt", flush_cnt, 0);
    rst = 1'b0;
    model_reset();
    tick();

    // Combinational table in RUN; events are withdrawn before each edge so the FSM stays put
    for (int k = 0; k < 15; k++) begin
      stall_req = vecs[k].sreq; predict_miss = vecs[k].pm; exp_en = vecs[k].ex;
      e_ret = vecs[k].er; idle_req = vecs[k].id;
      #1;
      check($sformatf("vec%0d flush", k), flush, vecs[k].f);
      check($sformatf("vec%0d stall", k), stall, vecs[k].s);
      check($sformatf("vec%0d bubble", k), bubble, vecs[k].b);
      clear_inputs();
      tick();
    end
    check("table no state change", {redirect_valid, idle_state}, 0);

    // Mispredict redirect held until accepted
    apply_reset();
    predict_miss = 1; real_addr = 32'h1c00_0100;
    #1;
    check("miss flush", flush, 5'b00011);
    tick();
    clear_inputs();
    check("miss redirect_valid", redirect_valid, 1);
    check("miss redirect_pc", redirect_pc, 32'h1c00_0100);
    for (int n = 0; n < 3; n++) begin
      #1;
      check("redirect flush0", flush, 5'b00001);
      tick();
      check("redirect held valid", redirect_valid, 1);
      check("redirect held pc", redirect_pc, 32'h1c00_0100);
    end
    redirect_ready = 1;
    tick();
    redirect_ready = 0;
    check("accept redirect_valid", redirect_valid, 0);
    check("accept flush_cnt", flush_cnt, 1);
    #1;
    check("run quiet flush", flush, 0);

    // Exception beats mispredict in the same cycle
    apply_reset();
    predict_miss = 1; real_addr = 32'h1c00_0200;
    exp_en = 1; trap_entry = 32'h1c00_8000;
    #1;
    check("exc+miss flush", flush, 5'b01111);
    tick();
    clear_inputs();
    check("exc+miss redirect_pc", redirect_pc, 32'h1c00_8000);

    // ertn replaces a pending redirect even when fetch accepts in that cycle; mispredict ignored
    apply_reset();
    predict_miss = 1; real_addr = 32'hA0;
    tick();
    clear_inputs();
    check("pre ertn pc", redirect_pc, 32'hA0);
    e_ret = 1; epc = 32'hB0; redirect_ready = 1;
    #1;
    check("ertn in redirect flush", flush, 5'b01111);
    tick();
    clear_inputs();
    check("ertn replace valid", redirect_valid, 1);
    check("ertn replace pc", redirect_pc, 32'hB0);
    check("ertn replace cnt", flush_cnt, 2);
    predict_miss = 1; real_addr = 32'hC0;
    tick();
    clear_inputs();
    check("miss ignored pc", redirect_pc, 32'hB0);
    check("miss ignored cnt", flush_cnt, 2);

    // Idle entry, ertn ignored while idle, exception wakes to trap vector
    apply_reset();
    idle_req = 1;
    #1;
    check("idle_req flush", flush, 5'b00111);
    tick();
    clear_inputs();
    check("idle entered", idle_state, 1);
    stall_req = 5'b01000;
    #1;
    check("idle flush0", flush, 5'b00001);
    check("idle stall", stall, 5'b01110);
    clear_inputs();
    e_ret = 1; epc = 32'h1234;
    tick();
    clear_inputs();
    check("idle ertn ignored state", idle_state, 1);
    check("idle ertn ignored valid", redirect_valid, 0);
    check("idle ertn ignored cnt", flush_cnt, 0);
    exp_en = 1; trap_entry = 32'h1c00_8000;
    #1;
    check("idle wake flush", flush, 5'b01111);
    tick();
    clear_inputs();
    check("idle wake state", idle_state, 0);
    check("idle wake valid", redirect_valid, 1);
    check("idle wake pc", redirect_pc, 32'h1c00_8000);
    check("idle wake cnt", flush_cnt, 1);

    // Asynchronous reset mid-redirect, then counter saturation
    rst = 1'b1;
    #1;
    check("async rst valid", redirect_valid, 0);
    check("async rst cnt", flush_cnt, 0);
    tick();
    rst = 1'b0;
    model_reset();
    tick();
    check("post rst valid", redirect_valid, 0);
    check("post rst idle", idle_state, 0);
    dut.cnt_q = 32'hFFFF_FFFE;
    predict_miss = 1; real_addr = 32'h40;
    tick();
    clear_inputs();
    check("cnt reaches max", flush_cnt, 32'hFFFF_FFFF);
    e_ret = 1; epc = 32'h80;
    tick();
    clear_inputs();
    check("cnt saturates", flush_cnt, 32'hFFFF_FFFF);
    check("sat pc", redirect_pc, 32'h80);

    // Randomized traffic against the reference model
    apply_reset();
    for (int n = 0; n < 2000; n++) begin
      predict_miss   = ($urandom_range(0, 3) == 0);
      exp_en         = ($urandom_range(0, 9) == 0);
      e_ret          = ($urandom_range(0, 11) == 0);
      idle_req       = ($urandom_range(0, 13) == 0);
      redirect_ready = ($urandom_range(0, 2) == 0);
      stall_req      = ($urandom_range(0, 1) == 0) ? '0 : ST'($urandom_range(0, 31));
      real_addr      = $urandom;
      trap_entry     = $urandom;
      epc            = $urandom;
      #1;
      model_comb(ef, es, eb, eld, enpc, eidle);
      check("rand flush", flush, ef);
      check("rand stall", stall, es);
      check("rand bubble", bubble, eb);
      tick();
      model_clock(eld, enpc, eidle);
      check("rand redirect_valid", redirect_valid, m_pending);
      check("rand redirect_pc", redirect_pc, m_pc);
      check("rand idle_state", idle_state, m_idle);
      check("rand flush_cnt", flush_cnt, m_cnt);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
